// File: rtl/branch_resolver.sv
// branch_resolver: holds predictions of in-flight conditional branches,
// compares them with execute outcomes, feeds outcome strobes back to the
// predictor and redirects/flushes the front end on a mispredict.
// Optional feature macro: BR_RESOLVER_STATS_EN (adds br_count/mispredict_count).
module branch_resolver #(
    parameter int unsigned PC_W         = 8,
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       issue,
    input  logic                       issue_pred,
    input  logic [PC_W-1:0]            issue_alt_pc,
    output logic                       issue_ready,
    input  logic                       resolve,
    input  logic                       resolve_taken,
    output logic                       outcome_valid,
    output logic                       outcome_taken,
    output logic                       redirect_valid,
    output logic [PC_W-1:0]            redirect_pc,
    output logic                       flush,
    output logic [$clog2(DEPTH+1)-1:0] inflight,
    output logic                       underflow
`ifdef BR_RESOLVER_STATS_EN
    ,
    output logic [15:0]                br_count,
    output logic [15:0]                mispredict_count
`endif
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned FC_W  = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam int unsigned ENT_W = PC_W + 1;

    typedef enum logic {RUN, FLUSH} state_e;

    state_e             state_q, state_d;
    logic [FC_W-1:0]    fcnt_q, fcnt_d;
    logic [ENT_W-1:0]   entry_q [DEPTH];
    logic [ENT_W-1:0]   entry_d [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               outcome_valid_q, outcome_valid_d;
    logic               outcome_taken_q, outcome_taken_d;
    logic               redirect_valid_q, redirect_valid_d;
    logic [PC_W-1:0]    redirect_pc_q, redirect_pc_d;
    logic               flush_q, flush_d;
    logic               underflow_q, underflow_d;
`ifdef BR_RESOLVER_STATS_EN
    logic [15:0]        br_count_q, br_count_d;
    logic [15:0]        mis_count_q, mis_count_d;
`endif

    logic             pop, mispredict, push;
    logic [ENT_W-1:0] head;

    // Accept new branches only while running and not full
    assign issue_ready = (state_q == RUN) && (count_q < CNT_W'(DEPTH));

    // Next-state, FIFO and strobe computation
    always_comb begin
        state_d          = state_q;
        fcnt_d           = fcnt_q;
        entry_d          = entry_q;
        wr_ptr_d         = wr_ptr_q;
        rd_ptr_d         = rd_ptr_q;
        count_d          = count_q;
        outcome_valid_d  = 1'b0;
        outcome_taken_d  = 1'b0;
        redirect_valid_d = 1'b0;
        redirect_pc_d    = redirect_pc_q;
        underflow_d      = underflow_q;
`ifdef BR_RESOLVER_STATS_EN
        br_count_d       = br_count_q;
        mis_count_d      = mis_count_q;
`endif

        head       = entry_q[rd_ptr_q];
        pop        = resolve && (state_q == RUN) && (count_q != '0);
        mispredict = pop && (resolve_taken != head[PC_W]);
        push       = issue && issue_ready && !mispredict;

        if (resolve && (state_q == RUN) && (count_q == '0)) begin
            underflow_d = 1'b1;
        end

        if (pop) begin
            outcome_valid_d = 1'b1;
            outcome_taken_d = resolve_taken;
`ifdef BR_RESOLVER_STATS_EN
            if (br_count_q != 16'hFFFF) br_count_d = br_count_q + 16'd1;
`endif
        end

        if (mispredict) begin
            // Squash everything younger, including a same-cycle issue
            redirect_valid_d = 1'b1;
            redirect_pc_d    = head[PC_W-1:0];
            wr_ptr_d         = '0;
            rd_ptr_d         = '0;
            count_d          = '0;
`ifdef BR_RESOLVER_STATS_EN
            if (mis_count_q != 16'hFFFF) mis_count_d = mis_count_q + 16'd1;
`endif
        end else begin
            if (push) begin
                entry_d[wr_ptr_q] = {issue_pred, issue_alt_pc};
                wr_ptr_d          = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end

        case (state_q)
            RUN: begin
                if (mispredict) begin
                    state_d = FLUSH;
                    fcnt_d  = FC_W'(FLUSH_CYCLES - 1);
                end
            end
            FLUSH: begin
                if (fcnt_q == '0) state_d = RUN;
                else              fcnt_d  = fcnt_q - FC_W'(1);
            end
            default: state_d = RUN;
        endcase

        flush_d = (state_d == FLUSH);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= RUN;
            fcnt_q           <= '0;
            for (int i = 0; i < int'(DEPTH); i++) entry_q[i] <= '0;
            wr_ptr_q         <= '0;
            rd_ptr_q         <= '0;
            count_q          <= '0;
            outcome_valid_q  <= 1'b0;
            outcome_taken_q  <= 1'b0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            flush_q          <= 1'b0;
            underflow_q      <= 1'b0;
`ifdef BR_RESOLVER_STATS_EN
            br_count_q       <= '0;
            mis_count_q      <= '0;
`endif
        end else begin
            state_q          <= state_d;
            fcnt_q           <= fcnt_d;
            entry_q          <= entry_d;
            wr_ptr_q         <= wr_ptr_d;
            rd_ptr_q         <= rd_ptr_d;
            count_q          <= count_d;
            outcome_valid_q  <= outcome_valid_d;
            outcome_taken_q  <= outcome_taken_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
            flush_q          <= flush_d;
            underflow_q      <= underflow_d;
`ifdef BR_RESOLVER_STATS_EN
            br_count_q       <= br_count_d;
            mis_count_q      <= mis_count_d;
`endif
        end
    end

    assign outcome_valid  = outcome_valid_q;
    assign outcome_taken  = outcome_taken_q;
    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;
    assign flush          = flush_q;
    assign inflight       = count_q;
    assign underflow      = underflow_q;
`ifdef BR_RESOLVER_STATS_EN
    assign br_count         = br_count_q;
    assign mispredict_count = mis_count_q;
`endif

endmodule

// File: tb/tb_branch_resolver.sv
// Self-checking bench for branch_resolver: directed scenarios followed by
// randomized traffic, all checked against a queue-based reference model.
module tb_branch_resolver;

    localparam int unsigned PC_W   = 8;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned FLUSHC = 2;
    localparam int unsigned CNT_W  = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             issue = 1'b0, issue_pred = 1'b0;
    logic [PC_W-1:0]  issue_alt_pc = '0;
    logic             issue_ready;
    logic             resolve = 1'b0, resolve_taken = 1'b0;
    logic             outcome_valid, outcome_taken, redirect_valid;
    logic [PC_W-1:0]  redirect_pc;
    logic             flush;
    logic [CNT_W-1:0] inflight;
    logic             underflow;
`ifdef BR_RESOLVER_STATS_EN
    logic [15:0]      br_count, mispredict_count;
`endif

    branch_resolver #(.PC_W(PC_W), .DEPTH(DEPTH), .FLUSH_CYCLES(FLUSHC)) dut (
        .clk(clk), .rst(rst),
        .issue(issue), .issue_pred(issue_pred), .issue_alt_pc(issue_alt_pc),
        .issue_ready(issue_ready),
        .resolve(resolve), .resolve_taken(resolve_taken),
        .outcome_valid(outcome_valid), .outcome_taken(outcome_taken),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .flush(flush), .inflight(inflight), .underflow(underflow)
`ifdef BR_RESOLVER_STATS_EN
        , .br_count(br_count), .mispredict_count(mispredict_count)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: queue of {pred, alt_pc}, remaining flush cycles
    logic [PC_W:0]   mq[$];
    int              m_flush_left = 0;
    logic            m_ov = 0, m_ot = 0, m_rv = 0, m_uf = 0;
    logic [PC_W-1:0] m_rpc = '0;
    int              m_br = 0, m_mis = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: check ready, apply inputs, advance model, check outputs
    task automatic step(input logic r, input logic i, input logic p, input logic [PC_W-1:0] a,
                        input logic rs, input logic t);
        logic ready, mis;
        logic [PC_W:0] h;
        ready = (m_flush_left == 0) && (mq.size() < DEPTH);
        check("issue_ready", 32'(issue_ready), 32'(ready));
        rst = r; issue = i; issue_pred = p; issue_alt_pc = a; resolve = rs; resolve_taken = t;
        @(posedge clk);
        #1;
        m_ov = 0; m_rv = 0; mis = 0;
        if (r) begin
            mq.delete(); m_flush_left = 0; m_rpc = '0; m_uf = 0; m_br = 0; m_mis = 0;
        end else if (m_flush_left > 0) begin
            m_flush_left--;
        end else begin
            if (rs) begin
                if (mq.size() == 0) m_uf = 1;
                else begin
                    h = mq.pop_front();
                    m_ov = 1; m_ot = t;
                    if (m_br < 65535) m_br++;
                    if (t != h[PC_W]) begin
                        mis = 1; m_rv = 1; m_rpc = h[PC_W-1:0];
                        mq.delete(); m_flush_left = FLUSHC;
                        if (m_mis < 65535) m_mis++;
                    end
                end
            end
            if (i && ready && !mis) mq.push_back({p, a});
        end
        check("outcome_valid", 32'(outcome_valid), 32'(m_ov));
        if (m_ov) check("outcome_taken", 32'(outcome_taken), 32'(m_ot));
        check("redirect_valid", 32'(redirect_valid), 32'(m_rv));
        if (m_rv) check("redirect_pc", 32'(redirect_pc), 32'(m_rpc));
        check("flush", 32'(flush), 32'(m_flush_left > 0));
        check("inflight", 32'(inflight), 32'(mq.size()));
        check("underflow", 32'(underflow), 32'(m_uf));
`ifdef BR_RESOLVER_STATS_EN
        check("br_count", 32'(br_count), 32'(m_br));
        check("mispredict_count", 32'(mispredict_count), 32'(m_mis));
`endif
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(0, 0, 0, '0, 0, 0);
    endtask

    initial begin
        logic tk, pr;
        // Bring registers out of X, then enter the checked sequence
        @(posedge clk); #1;
        step(1, 0, 0, '0, 0, 0);
        check("reset_flush", 32'(flush), 32'd0);

        // Correct prediction
        step(0, 1, 1, 8'h10, 0, 0);
        step(0, 0, 0, '0, 1, 1);
        idle(1);

        // Mispredict: redirect to 0x22 and flush two cycles
        step(0, 1, 1, 8'h22, 0, 0);
        step(0, 0, 0, '0, 1, 0);
        check("redirect_pc_22", 32'(redirect_pc), 32'h22);
        idle(3);

        // Fill, drop a fifth issue, drain in order, issue after wrap
        for (int k = 0; k < 5; k++) step(0, 1, k[0], 8'(8'h30 + k), 0, 0);
        for (int k = 0; k < 4; k++) step(0, 0, 0, '0, 1, k[0]);
        step(0, 1, 1, 8'h40, 0, 0);
        step(0, 0, 0, '0, 1, 1);

        // Same-cycle issue and resolve, correct then mispredicted
        step(0, 1, 0, 8'h50, 0, 0);
        step(0, 1, 1, 8'h51, 0, 0);
        step(0, 1, 0, 8'h52, 1, 0);
        step(0, 1, 0, 8'h53, 1, 0);
        idle(3);

        // Empty resolve sets sticky underflow; reset during flush
        step(0, 0, 0, '0, 1, 1);
        idle(2);
        step(0, 1, 0, 8'h60, 0, 0);
        step(0, 0, 0, '0, 1, 1);
        step(0, 0, 0, '0, 1, 1);
        step(1, 0, 0, '0, 0, 0);
        idle(1);

        // Stats scenario: three correct, two mispredicted
        for (int k = 0; k < 3; k++) begin
            step(0, 1, 1, 8'(8'h70 + k), 0, 0);
            step(0, 0, 0, '0, 1, 1);
        end
        for (int k = 0; k < 2; k++) begin
            step(0, 1, 0, 8'(8'h80 + k), 0, 0);
            step(0, 0, 0, '0, 1, 1);
            idle(3);
        end

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            pr = 1'($urandom);
            if (mq.size() > 0 && $urandom_range(0, 4) != 0) tk = mq[0][PC_W];
            else tk = 1'($urandom);
            step(1'($urandom_range(0, 199) == 0), 1'($urandom_range(0, 99) < 55), pr,
                 8'($urandom), 1'($urandom_range(0, 99) < 40), tk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
